// File: rtl/div_ratio_ctrl.sv
// ---------------------------------------------------------------------------
// div_ratio_ctrl
//
// Programmable power-of-two clock divider with glitch-free ratio changes.
// The output f_div has a period of 2^cur_n clk cycles and a 50% duty cycle.
// A new exponent is requested through a valid/ready handshake. The switch to
// the new ratio is deferred to the next falling edge of f_div. Because of
// that, the output never produces a shortened (runt) high or low phase.
//
// Optional feature (macro DIV_LOCK_EN):
//   defined   - after every ratio change, and after reset, the block waits
//               LOCK_PERIODS rising edges of f_div in a LOCK state before
//               locked asserts and new requests are taken.
//   undefined - there is no LOCK state. locked simply means "in RUN and not
//               in reset".
//
// Parameters:
//   RST_N         exponent loaded at reset (ratio 2^RST_N), legal 1..7
//   LOCK_PERIODS  f_div rising edges counted before lock, legal 1..15
//
// Ports:
//   clk        single clock, all logic on its rising edge
//   rst        synchronous, active-high reset
//   req_valid  ratio-change request
//   req_n      requested exponent (ratio 2^req_n); 0 is illegal
//   req_ready  request accepted when req_valid && req_ready (RUN only)
//   f_div      registered divided clock, 50% duty
//   tick       one-cycle pulse in the first cycle of every new f_div level
//   cur_n      exponent currently driving f_div
//   done       one-cycle pulse when a request completes
//   err        one-cycle pulse after an accepted illegal request (req_n = 0)
//   locked     output stable at cur_n
// ---------------------------------------------------------------------------
module div_ratio_ctrl #(
  parameter int RST_N        = 1,
  parameter int LOCK_PERIODS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [2:0] req_n,
  output logic       req_ready,
  output logic       f_div,
  output logic       tick,
  output logic [2:0] cur_n,
  output logic       done,
  output logic       err,
  output logic       locked
);

`ifdef DIV_LOCK_EN
  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PEND = 2'd1,
    S_LOCK = 2'd2
  } state_t;
  localparam state_t RESET_STATE = S_LOCK;
`else
  typedef enum logic {
    S_RUN  = 1'b0,
    S_PEND = 1'b1
  } state_t;
  localparam state_t RESET_STATE = S_RUN;
`endif

  state_t     state;
  state_t     next_state;

  // Half-period counter. The largest exponent, 7, gives a half period of
  // 64 cycles, so the counter runs 0..63.
  logic [5:0] cnt;
  logic [6:0] half_len;
  logic [6:0] term_cnt;
  logic       at_term;
  logic       fall;

  // Exponent captured on acceptance and applied at the next f_div fall.
  logic [2:0] pend_n;

  // Decoded control strobes from the FSM.
  logic       accept;
  logic       load_pend;
  logic       set_err;
  logic       set_done_same;
  logic       do_switch;

`ifdef DIV_LOCK_EN
  logic       rise;
  logic [3:0] lock_cnt;
  logic       lock_inc;
  logic       set_locked;
  logic       locked_q;
`endif

  // -------------------------------------------------------------------------
  // Divider timing decode
  // -------------------------------------------------------------------------
  // The half period is 2^(cur_n-1) cycles. The terminal count is one less.
  // This is computed in 7 bits so that cur_n = 7 (64) does not wrap.
  assign half_len = 7'd1 << (cur_n - 3'd1);
  assign term_cnt = half_len - 7'd1;
  assign at_term  = ({1'b0, cnt} == term_cnt);
  assign fall     = at_term && f_div;
`ifdef DIV_LOCK_EN
  assign rise     = at_term && !f_div;
`endif

  // req_ready is gated by rst so that a request shown during reset is never
  // accepted, whatever the state register holds at that moment.
  assign req_ready = (state == S_RUN) && !rst;
  assign accept    = req_valid && req_ready;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments. All flops then sample
  // their pre-edge values, and the processes do not race on evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_STATE;
    end else begin
      state <= next_state;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state and control decode
  // -------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case
  // statement. An output missed on one path would otherwise become a latch.
  always_comb begin
    next_state    = state;
    load_pend     = 1'b0;
    set_err       = 1'b0;
    set_done_same = 1'b0;
    do_switch     = 1'b0;
`ifdef DIV_LOCK_EN
    lock_inc      = 1'b0;
    set_locked    = 1'b0;
`endif
    case (state)
      S_RUN: begin
        if (accept) begin
          if (req_n == 3'd0) begin
            set_err = 1'b1;
          end else if (req_n == cur_n) begin
            set_done_same = 1'b1;
          end else begin
            load_pend  = 1'b1;
            next_state = S_PEND;
          end
        end
      end
      S_PEND: begin
        // Switch only at the terminal count that ends a high phase. The old
        // period then finishes exactly, and the new one starts low from 0.
        if (fall) begin
          do_switch = 1'b1;
`ifdef DIV_LOCK_EN
          next_state = S_LOCK;
`else
          next_state = S_RUN;
`endif
        end
      end
`ifdef DIV_LOCK_EN
      S_LOCK: begin
        if (rise) begin
          if (lock_cnt == 4'(LOCK_PERIODS - 1)) begin
            set_locked = 1'b1;
            next_state = S_RUN;
          end else begin
            lock_inc = 1'b1;
          end
        end
      end
`endif
      default: begin
        next_state = RESET_STATE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Divider datapath and output pulses
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      f_div  <= 1'b0;
      tick   <= 1'b0;
      cur_n  <= 3'(RST_N);
      pend_n <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      // tick is high during the first cycle of each new f_div level.
      tick <= at_term;
      err  <= set_err;
      done <= set_done_same || do_switch;

      if (at_term) begin
        cnt   <= '0;
        f_div <= ~f_div;
      end else begin
        cnt <= cnt + 6'd1;
      end

      if (load_pend) begin
        pend_n <= req_n;
      end

      // do_switch only fires on a fall edge. f_div drops and cnt clears
      // through the normal toggle path above, so the new ratio starts from a
      // clean low phase.
      if (do_switch) begin
        cur_n <= pend_n;
      end
    end
  end

`ifdef DIV_LOCK_EN
  // -------------------------------------------------------------------------
  // Lock tracking: counts f_div rising edges while in LOCK
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt <= '0;
      locked_q <= 1'b0;
    end else begin
      if (do_switch) begin
        lock_cnt <= '0;
      end else if (lock_inc) begin
        lock_cnt <= lock_cnt + 4'd1;
      end

      if (load_pend) begin
        locked_q <= 1'b0;
      end else if (set_locked) begin
        locked_q <= 1'b1;
      end
    end
  end

  assign locked = locked_q;
`else
  assign locked = (state == S_RUN) && !rst;
`endif

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_ratio_ctrl
//
// Directed bench for div_ratio_ctrl with RST_N=2 and LOCK_PERIODS=4. The
// scenarios run back to back, so each task starts from the divider phase left
// by the one before it. The expected waveforms below are counted by hand from
// reset release. Expectations that depend on the optional lock feature are
// selected with LOCK_EN.
// ---------------------------------------------------------------------------
module tb_div_ratio_ctrl;

`ifdef DIV_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [2:0] req_n;
  logic       req_ready;
  logic       f_div;
  logic       tick;
  logic [2:0] cur_n;
  logic       done;
  logic       err;
  logic       locked;

  int total;
  int bad;

  div_ratio_ctrl #(
    .RST_N        (2),
    .LOCK_PERIODS (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_n     (req_n),
    .req_ready (req_ready),
    .f_div     (f_div),
    .tick      (tick),
    .cur_n     (cur_n),
    .done      (done),
    .err       (err),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset values, requests ignored during reset, cadence at n=2, and the
  // lock after reset (4th f_div rise lands on edge 14 after release).
  task automatic test_reset();
    logic exp_f, exp_t, exp_l, exp_r;
    rst       = 1'b1;
    req_valid = 1'b1;
    req_n     = 3'd3;
    for (int i = 0; i < 3; i++) step();
    total++;
    if ({f_div, tick, done, err, locked, req_ready} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got f_div=%b tick=%b done=%b err=%b locked=%b ready=%b, want all 0",
               f_div, tick, done, err, locked, req_ready);
    end
    total++;
    if (cur_n !== 3'd2) begin
      bad++;
      $display("FAIL reset_cur_n: got %0d want 2", cur_n);
    end
    rst       = 1'b0;
    req_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_f = ((k >> 1) & 1) == 1;
      exp_t = (k % 2) == 0;
      exp_l = LOCK_EN ? (k >= 14) : 1'b1;
      exp_r = exp_l;
      total++;
      if ({f_div, tick, cur_n} !== {exp_f, exp_t, 3'd2}) begin
        bad++;
        $display("FAIL reset_cadence k=%0d: got f_div=%b tick=%b cur_n=%0d want %b %b 2",
                 k, f_div, tick, cur_n, exp_f, exp_t);
      end
      total++;
      if ({locked, req_ready} !== {exp_l, exp_r}) begin
        bad++;
        $display("FAIL reset_lock k=%0d: got locked=%b ready=%b want %b %b",
                 k, locked, req_ready, exp_l, exp_r);
      end
    end
  endtask

  // Illegal exponent 0: err pulses, and nothing else changes (k continues 17..20).
  task automatic test_err();
    logic exp_f, exp_t;
    req_valid = 1'b1;
    req_n     = 3'd0;
    for (int k = 17; k <= 20; k++) begin
      step();
      req_valid = 1'b0;
      exp_f = ((k >> 1) & 1) == 1;
      exp_t = (k % 2) == 0;
      total++;
      if ({err, done} !== {(k == 17), 1'b0}) begin
        bad++;
        $display("FAIL err_pulse k=%0d: got err=%b done=%b want %b 0", k, err, done, (k == 17));
      end
      total++;
      if ({f_div, tick, cur_n, req_ready, locked} !== {exp_f, exp_t, 3'd2, 1'b1, 1'b1}) begin
        bad++;
        $display("FAIL err_cadence k=%0d: got f_div=%b tick=%b cur_n=%0d ready=%b locked=%b",
                 k, f_div, tick, cur_n, req_ready, locked);
      end
    end
  endtask

  // n=2 -> n=3 requested while f_div=1 in mid half-period (edge 23). The switch
  // happens on edge 24, and j counts edges from that switch.
  task automatic test_ratio_change();
    logic exp_f, exp_t, exp_l;
    step();  // k=21
    step();  // k=22: f_div has just risen
    req_valid = 1'b1;
    req_n     = 3'd3;
    step();  // k=23: accepted
    req_valid = 1'b0;
    total++;
    if ({f_div, req_ready, locked, done, cur_n} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd2}) begin
      bad++;
      $display("FAIL chg_accept: got f_div=%b ready=%b locked=%b done=%b cur_n=%0d want 1 0 0 0 2",
               f_div, req_ready, locked, done, cur_n);
    end
    step();  // k=24: old half-period completes, switch
    total++;
    if ({f_div, tick, done, cur_n} !== {1'b0, 1'b1, 1'b1, 3'd3}) begin
      bad++;
      $display("FAIL chg_switch: got f_div=%b tick=%b done=%b cur_n=%0d want 0 1 1 3",
               f_div, tick, done, cur_n);
    end
    for (int j = 1; j <= 32; j++) begin
      step();
      exp_f = ((j >> 2) & 1) == 1;
      exp_t = (j % 4) == 0;
      exp_l = LOCK_EN ? (j >= 28) : 1'b1;
      total++;
      if ({f_div, tick, done, cur_n} !== {exp_f, exp_t, 1'b0, 3'd3}) begin
        bad++;
        $display("FAIL chg_cadence j=%0d: got f_div=%b tick=%b done=%b cur_n=%0d want %b %b 0 3",
                 j, f_div, tick, done, cur_n, exp_f, exp_t);
      end
      total++;
      if (locked !== exp_l) begin
        bad++;
        $display("FAIL chg_locked j=%0d: got %b want %b", j, locked, exp_l);
      end
    end
  endtask

  // A request equal to cur_n completes at once with done, and locked is kept.
  task automatic test_same_ratio();
    req_valid = 1'b1;
    req_n     = 3'd3;
    step();
    req_valid = 1'b0;
    total++;
    if ({done, err, locked, req_ready, cur_n} !== {1'b1, 1'b0, 1'b1, 1'b1, 3'd3}) begin
      bad++;
      $display("FAIL same_done: got done=%b err=%b locked=%b ready=%b cur_n=%0d want 1 0 1 1 3",
               done, err, locked, req_ready, cur_n);
    end
    step();
    total++;
    if ({done, f_div} !== 2'b00) begin
      bad++;
      $display("FAIL same_after: got done=%b f_div=%b want 0 0", done, f_div);
    end
  endtask

  // n=5 is accepted at rel 0. n=1 is then held valid until it is accepted,
  // and rel counts edges from the n=5 acceptance.
  task automatic test_back_to_back();
    int  ready_rel, done1_rel, done2_rel, exp_ready, exp_done2;
    bit  acc;
    logic [2:0] n_at_done1, n_at_done2;
    logic exp_l;
    ready_rel = -1; done1_rel = -1; done2_rel = -1;
    n_at_done1 = 3'd0; n_at_done2 = 3'd0;
    exp_ready = LOCK_EN ? 117 : 5;
    exp_done2 = LOCK_EN ? 133 : 37;
    req_valid = 1'b1;
    req_n     = 3'd5;
    step();  // rel 0
    req_n = 3'd1;
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_busy: got ready=%b want 0", req_ready);
    end
    for (int rel = 1; rel <= 250 && done2_rel < 0; rel++) begin
      acc = req_valid && req_ready;
      step();
      if (acc) req_valid = 1'b0;
      if (req_ready && ready_rel < 0) ready_rel = rel;
      if (done) begin
        if (done1_rel < 0) begin
          done1_rel = rel; n_at_done1 = cur_n;
        end else begin
          done2_rel = rel; n_at_done2 = cur_n;
        end
      end
    end
    req_valid = 1'b0;
    total++;
    if (done1_rel != 5 || n_at_done1 !== 3'd5) begin
      bad++;
      $display("FAIL b2b_first_done: got rel=%0d cur_n=%0d want rel=5 cur_n=5", done1_rel, n_at_done1);
    end
    total++;
    if (ready_rel != exp_ready) begin
      bad++;
      $display("FAIL b2b_ready: got first ready at rel=%0d want %0d", ready_rel, exp_ready);
    end
    total++;
    if (done2_rel != exp_done2 || n_at_done2 !== 3'd1) begin
      bad++;
      $display("FAIL b2b_second_done: got rel=%0d cur_n=%0d want rel=%0d cur_n=1 (-1 = timeout)",
               done2_rel, n_at_done2, exp_done2);
    end
    // At n=1, f_div toggles every cycle and tick stays high. Lock (if built in)
    // lands on the 4th rise: i=7.
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_l = LOCK_EN ? (i >= 7) : 1'b1;
      total++;
      if ({f_div, tick, cur_n, locked} !== {(i % 2) == 1, 1'b1, 3'd1, exp_l}) begin
        bad++;
        $display("FAIL b2b_n1 i=%0d: got f_div=%b tick=%b cur_n=%0d locked=%b want %b 1 1 %b",
                 i, f_div, tick, cur_n, locked, (i % 2) == 1, exp_l);
      end
    end
  endtask

  // One reset cycle while in PEND discards the request. No done follows.
  task automatic test_reset_in_pend();
    req_valid = 1'b1;
    req_n     = 3'd4;
    step();  // accepted -> PEND
    req_valid = 1'b0;
    total++;
    if ({req_ready, locked} !== 2'b00) begin
      bad++;
      $display("FAIL rip_pend: got ready=%b locked=%b want 0 0", req_ready, locked);
    end
    rst = 1'b1;
    step();
    total++;
    if ({f_div, tick, done, err, locked, req_ready, cur_n} !== {6'b0, 3'd2}) begin
      bad++;
      $display("FAIL rip_reset: got f_div=%b tick=%b done=%b err=%b locked=%b ready=%b cur_n=%0d",
               f_div, tick, done, err, locked, req_ready, cur_n);
    end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      total++;
      if ({done, cur_n, f_div, tick} !== {1'b0, 3'd2, ((k >> 1) & 1) == 1, (k % 2) == 0}) begin
        bad++;
        $display("FAIL rip_after k=%0d: got done=%b cur_n=%0d f_div=%b tick=%b",
                 k, done, cur_n, f_div, tick);
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_n     = 3'd0;
    test_reset();
    test_err();
    test_ratio_change();
    test_same_ratio();
    test_back_to_back();
    test_reset_in_pend();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
